// File: rtl/apb_slave_mem.sv
// APB completer with a small word-addressed register file, programmable base address and
// a fixed number of wait states before each PREADY.
module apb_slave_mem #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    DEPTH       = 8,
    parameter int                    WAIT_CYCLES = 1
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSLVERR
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

    state_t                state, state_nx;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [3:0]            cnt;
    logic [IW-1:0]         idx_q;
    logic                  range_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  setup, access;
    logic                  latch_en, load_rsp, commit;
    logic [ADDR_WIDTH-1:0] offset;
    logic                  live_in_range;
    logic [IW-1:0]         rsp_idx;
    logic                  rsp_range, rsp_write;

    assign setup  = PSEL & ~PENABLE;
    assign access = PSEL & PENABLE;

    // The range test uses the full-width offset so aliased addresses above the window are rejected.
    assign offset        = PADDR - BASE_ADDR;
    assign live_in_range = (PADDR >= BASE_ADDR) && (offset < ADDR_WIDTH'(DEPTH));

    // With zero wait states the response is loaded on the setup edge, before the latches hold anything.
    assign rsp_idx   = (state == S_IDLE) ? offset[IW-1:0] : idx_q;
    assign rsp_range = (state == S_IDLE) ? live_in_range  : range_q;
    assign rsp_write = (state == S_IDLE) ? PWRITE         : write_q;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= S_IDLE;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            state <= state_nx;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, otherwise a latch is inferred.
        state_nx = state;
        latch_en = 1'b0;
        load_rsp = 1'b0;
        commit   = 1'b0;
        case (state)
            S_IDLE: begin
                if (setup) begin
                    latch_en = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nx = S_READY;
                        load_rsp = 1'b1;
                    end else begin
                        state_nx = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!PSEL) begin
                    state_nx = S_IDLE;
                end else if (PENABLE && cnt == 4'd1) begin
                    state_nx = S_READY;
                    load_rsp = 1'b1;
                end
            end
            S_READY: begin
                state_nx = S_IDLE;
                commit   = access & write_q & range_q;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            cnt     <= '0;
            idx_q   <= '0;
            range_q <= 1'b0;
            write_q <= 1'b0;
            wdata_q <= '0;
            PREADY  <= 1'b0;
            PRDATA  <= '0;
            PSLVERR <= 1'b0;
        end else begin
            PREADY <= load_rsp;
            if (load_rsp) begin
                PSLVERR <= ~rsp_range;
                PRDATA  <= (!rsp_write && rsp_range) ? mem[rsp_idx] : '0;
            end else begin
                PSLVERR <= 1'b0;
                PRDATA  <= '0;
            end

            if (latch_en) begin
                idx_q   <= offset[IW-1:0];
                range_q <= live_in_range;
                write_q <= PWRITE;
                wdata_q <= PWDATA;
                cnt     <= 4'(WAIT_CYCLES);
            end else if (state == S_WAIT && access && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            // NOTE: the storage array is cleared by reset, so it maps to flops rather than a RAM macro.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (commit) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: four instances cover base offset and 0/1/3 wait states.
module tb_apb_slave_mem;

    logic        clk = 1'b0;
    logic        preset;
    logic [3:0]  psel;
    logic        penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pready, pslverr;
    logic [31:0] prdata [4];

    int checks = 0;
    int errors = 0;
    int dbl    = 0;
    logic [3:0] prev_ready = '0;

    always #5 clk = ~clk;

    // k=0: base 0, 1 wait; k=1: base 8, 1 wait; k=2: base 0, 0 waits; k=3: base 0, 3 waits
    apb_slave_mem #(.BASE_ADDR(32'd0), .WAIT_CYCLES(1)) u0 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0]));
    apb_slave_mem #(.BASE_ADDR(32'd8), .WAIT_CYCLES(1)) u1 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1]));
    apb_slave_mem #(.BASE_ADDR(32'd0), .WAIT_CYCLES(0)) u2 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready[2]), .PRDATA(prdata[2]), .PSLVERR(pslverr[2]));
    apb_slave_mem #(.BASE_ADDR(32'd0), .WAIT_CYCLES(3)) u3 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel[3]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready[3]), .PRDATA(prdata[3]), .PSLVERR(pslverr[3]));

    // PREADY must never be high in two consecutive cycles on any instance.
    always @(negedge clk) begin
        if ((pready & prev_ready) != 4'b0) dbl++;
        prev_ready = pready;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete transfer; returns at the falling edge of the PREADY cycle.
    task automatic xfer(input int k, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        output logic [31:0] rdata, output logic err, output int lat);
        bit got = 0;
        @(posedge clk); #1;
        psel    = 4'b0;
        psel[k] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        @(posedge clk); #1;
        penable = 1'b1;
        paddr   = addr ^ 32'h5;   // access-phase address/data must be ignored
        pwdata  = ~data;
        rdata   = 32'hBAD0_0000;
        err     = 1'bx;
        lat     = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (pready[k]) begin
                rdata = prdata[k];
                err   = pslverr[k];
                got   = 1;
            end else begin
                lat++;
            end
        end
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        psel    = 4'b0;
        penable = 1'b0;
    endtask

    task automatic rd_check(input string name, input int k, input logic [31:0] addr,
                            input logic [31:0] exp, input logic exp_err, input int exp_lat);
        logic [31:0] rd;
        logic        er;
        int          lt;
        xfer(k, 1'b0, addr, 32'h0, rd, er, lt);
        check({name, ".rdata"}, rd, exp);
        check({name, ".err"}, 32'(er), 32'(exp_err));
        check({name, ".lat"}, lt, exp_lat);
    endtask

    typedef struct {
        int          k;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vt [22];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lt;
        logic [3:0]  seen;

        vt[0]  = '{0, 1'b1, 32'd3,         32'hDEAD_BEEF, 32'h0,         1'b0, 1};
        vt[1]  = '{0, 1'b0, 32'd3,         32'h0,         32'hDEAD_BEEF, 1'b0, 1};
        vt[2]  = '{1, 1'b1, 32'd20,        32'h55,        32'h0,         1'b1, 1};
        vt[3]  = '{1, 1'b0, 32'd8,         32'h0,         32'h0,         1'b0, 1};
        vt[4]  = '{1, 1'b0, 32'd15,        32'h0,         32'h0,         1'b0, 1};
        vt[5]  = '{1, 1'b0, 32'd7,         32'h0,         32'h0,         1'b1, 1};
        vt[6]  = '{1, 1'b0, 32'd16,        32'h0,         32'h0,         1'b1, 1};
        vt[7]  = '{1, 1'b1, 32'd12,        32'hA5A5_0F0F, 32'h0,         1'b0, 1};
        vt[8]  = '{1, 1'b0, 32'd12,        32'h0,         32'hA5A5_0F0F, 1'b0, 1};
        vt[9]  = '{2, 1'b1, 32'd0,         32'h1,         32'h0,         1'b0, 0};
        vt[10] = '{2, 1'b1, 32'd7,         32'h7,         32'h0,         1'b0, 0};
        vt[11] = '{2, 1'b0, 32'd0,         32'h0,         32'h1,         1'b0, 0};
        vt[12] = '{2, 1'b0, 32'd7,         32'h0,         32'h7,         1'b0, 0};
        vt[13] = '{2, 1'b0, 32'd8,         32'h0,         32'h0,         1'b1, 0};
        vt[14] = '{3, 1'b1, 32'd5,         32'h1234_5678, 32'h0,         1'b0, 3};
        vt[15] = '{3, 1'b0, 32'd5,         32'h0,         32'h1234_5678, 1'b0, 3};
        vt[16] = '{0, 1'b1, 32'd0,         32'h1,         32'h0,         1'b0, 1};
        vt[17] = '{0, 1'b1, 32'd7,         32'h7,         32'h0,         1'b0, 1};
        vt[18] = '{0, 1'b0, 32'd0,         32'h0,         32'h1,         1'b0, 1};
        vt[19] = '{0, 1'b0, 32'd7,         32'h0,         32'h7,         1'b0, 1};
        vt[20] = '{0, 1'b0, 32'h103,       32'h0,         32'h0,         1'b1, 1};
        vt[21] = '{1, 1'b0, 32'h8000_000A, 32'h0,         32'h0,         1'b1, 1};

        preset  = 1'b1;
        psel    = 4'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        #2;
        check("reset.pready",  32'(pready),  32'h0);
        check("reset.pslverr", 32'(pslverr), 32'h0);
        check("reset.prdata0", prdata[0],    32'h0);
        check("reset.prdata3", prdata[3],    32'h0);
        repeat (2) @(posedge clk);
        #1 preset = 1'b0;

        // All table vectors run back-to-back with no idle cycles in between.
        foreach (vt[i]) begin
            xfer(vt[i].k, vt[i].wr, vt[i].addr, vt[i].data, rd, er, lt);
            check($sformatf("vec%0d.rdata", i), rd, vt[i].exp_rd);
            check($sformatf("vec%0d.err", i), 32'(er), 32'(vt[i].exp_err));
            check($sformatf("vec%0d.lat", i), lt, vt[i].exp_lat);
        end
        go_idle();

        // Out-of-range write on the base-8 slave corrupted nothing.
        for (int a = 8; a < 16; a++)
            rd_check($sformatf("scan%0d", a), 1, a, (a == 12) ? 32'hA5A5_0F0F : 32'h0, 1'b0, 1);
        go_idle();

        // Access phase without a setup phase is ignored.
        @(posedge clk); #1;
        psel = 4'b0001; penable = 1'b1; pwrite = 1'b1; paddr = 32'd1; pwdata = 32'hFF;
        seen = '0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | pready;
        end
        check("nosetup.pready", 32'(seen), 32'h0);
        go_idle();
        rd_check("nosetup.mem1", 0, 32'd1, 32'h0, 1'b0, 1);
        go_idle();

        // Abort: PSEL dropped while waiting on a write to addr 2.
        @(posedge clk); #1;
        psel = 4'b1000; penable = 1'b0; pwrite = 1'b1; paddr = 32'd2; pwdata = 32'h55;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 4'b0; penable = 1'b0;
        seen = '0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | pready;
        end
        check("abort.pready", 32'(seen), 32'h0);
        rd_check("abort.mem2", 3, 32'd2, 32'h0, 1'b0, 3);
        go_idle();

        // Asynchronous reset asserted while a read response is on the bus.
        xfer(0, 1'b0, 32'd3, 32'h0, rd, er, lt);
        check("prereset.rdata", rd, 32'hDEAD_BEEF);
        #1 preset = 1'b1;
        #1;
        check("async.pready",  32'(pready[0]),  32'h0);
        check("async.prdata",  prdata[0],       32'h0);
        check("async.pslverr", 32'(pslverr[0]), 32'h0);
        @(posedge clk); #1;
        psel = 4'b0; penable = 1'b0;
        @(posedge clk); #1;
        preset = 1'b0;

        // Reset mid-WAIT on a write: nothing commits.
        @(posedge clk); #1;
        psel = 4'b1000; penable = 1'b0; pwrite = 1'b1; paddr = 32'd4; pwdata = 32'h99;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        preset = 1'b1;
        #1;
        check("midwait.pready", 32'(pready[3]), 32'h0);
        @(posedge clk); #1;
        psel = 4'b0; penable = 1'b0;
        preset = 1'b0;

        rd_check("post.u0a3", 0, 32'd3,  32'h0, 1'b0, 1);
        rd_check("post.u0a7", 0, 32'd7,  32'h0, 1'b0, 1);
        rd_check("post.u1a12", 1, 32'd12, 32'h0, 1'b0, 1);
        rd_check("post.u3a5", 3, 32'd5,  32'h0, 1'b0, 3);
        rd_check("post.u3a4", 3, 32'd4,  32'h0, 1'b0, 3);
        go_idle();
        @(negedge clk);

        check("pready.double", dbl, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
